// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Latency: an L-byte read pulses done L+1 edges after the grant edge, an L-byte store L edges after it.
// Backpressure: requests hold until done; MEM_ARB_IO_STALL_EN holds IO-region store bytes while io_buffer_full.
module mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              roll,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              IF_flag,
    input  logic [ADDR_W-1:0] IF_PC,
    output logic              IF_done,
    output logic [31:0]       IF_inst,
    input  logic              LSB_flag,
    input  logic              LSB_op,
    input  logic [ADDR_W-1:0] LSB_PC,
    input  logic [2:0]        LSB_LS_len,
    input  logic [31:0]       LSB_data,
    output logic              LSB_done,
    output logic [31:0]       LSB_val
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_q, last_d;      // 1 = LSB owns the current/last access
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       lsb_val_q, lsb_val_d;

    logic io_full;
`ifdef MEM_ARB_IO_STALL_EN
    assign io_full = io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_full = 1'b0;
`endif

    function automatic logic io_hold(input logic full, input logic [ADDR_W-1:0] a);
        return full && (a[17:16] == IO_SEL);
    endfunction

    logic              if_req, lsb_req, grant_lsb, grant_if;
    logic [2:0]        lsb_len;
    logic [1:0]        rd_idx;
    logic [ADDR_W-1:0] next_a;

    // A requester still showing its done pulse is not re-granted; IF wins right after an LSB grant.
    assign if_req    = IF_flag && !if_done_q;
    assign lsb_req   = LSB_flag && !lsb_done_q;
    assign grant_lsb = lsb_req && !(last_q && if_req);
    assign grant_if  = if_req && !grant_lsb;
    assign lsb_len   = (LSB_LS_len == 3'd1 || LSB_LS_len == 3'd2) ? LSB_LS_len : 3'd4;
    assign rd_idx    = cnt_q[1:0] - 2'd2;
    assign next_a    = base_q + ADDR_W'(cnt_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        base_d     = base_q;
        len_d      = len_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        if_inst_d  = if_inst_q;
        lsb_done_d = 1'b0;
        lsb_val_d  = lsb_val_q;
        case (state_q)
            S_IDLE: begin
                mem_wr_d = 1'b0;
                if (!roll) begin
                    if (grant_lsb) begin
                        last_d  = 1'b1;
                        base_d  = LSB_PC;
                        len_d   = lsb_len;
                        mem_a_d = LSB_PC;
                        cnt_d   = 3'd1;
                        if (LSB_op) begin
                            state_d    = S_WRITE;
                            buf_d      = LSB_data;
                            mem_dout_d = LSB_data[7:0];
                            mem_wr_d   = !io_hold(io_full, LSB_PC);
                        end else begin
                            state_d = S_READ;
                            buf_d   = '0;
                        end
                    end else if (grant_if) begin
                        last_d  = 1'b0;
                        base_d  = IF_PC;
                        len_d   = 3'd4;
                        mem_a_d = IF_PC;
                        cnt_d   = 3'd1;
                        state_d = S_READ;
                        buf_d   = '0;
                    end
                end
            end
            S_READ: begin
                if (roll) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    mem_wr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < len_q) begin
                        mem_a_d = next_a;
                    end
                    // RAM data lags the address by one cycle, so edge k captures byte k-2.
                    if (cnt_q >= 3'd2) begin
                        buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        if (last_q) begin
                            lsb_done_d = 1'b1;
                            lsb_val_d  = buf_d;
                        end else begin
                            if_done_d = 1'b1;
                            if_inst_d = buf_d;
                        end
                    end
                end
            end
            S_WRITE: begin
                // Stores are committed: roll does not interrupt them.
                if (!mem_wr_q) begin
                    if (!io_hold(io_full, mem_a_q)) begin
                        mem_wr_d = 1'b1;
                    end
                end else if (cnt_q == len_q) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    mem_wr_d   = 1'b0;
                    lsb_done_d = 1'b1;
                end else begin
                    mem_a_d    = next_a;
                    mem_dout_d = buf_q[{cnt_q[1:0], 3'b000} +: 8];
                    cnt_d      = cnt_q + 3'd1;
                    mem_wr_d   = !io_hold(io_full, next_a);
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_inst_q  <= '0;
            lsb_done_q <= 1'b0;
            lsb_val_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            base_q     <= base_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            if_inst_q  <= if_inst_d;
            lsb_done_q <= lsb_done_d;
            lsb_val_q  <= lsb_val_d;
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign IF_done  = if_done_q;
    assign IF_inst  = if_inst_q;
    assign LSB_done = lsb_done_q;
    assign LSB_val  = lsb_val_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a byte RAM model with a one-cycle read latency.
// Expected values are hand-derived constants; edge indices count from the grant edge (index 0).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, roll, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        IF_flag, IF_done;
    logic [31:0] IF_PC, IF_inst;
    logic        LSB_flag, LSB_op, LSB_done;
    logic [31:0] LSB_PC, LSB_data, LSB_val;
    logic [2:0]  LSB_LS_len;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .roll(roll), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .IF_flag(IF_flag), .IF_PC(IF_PC), .IF_done(IF_done), .IF_inst(IF_inst),
        .LSB_flag(LSB_flag), .LSB_op(LSB_op), .LSB_PC(LSB_PC), .LSB_LS_len(LSB_LS_len),
        .LSB_data(LSB_data), .LSB_done(LSB_done), .LSB_val(LSB_val)
    );

    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        mem_din <= ram[mem_a[9:0]];
        if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_req(input logic op, input logic [31:0] pc, input logic [2:0] len,
                           input logic [31:0] data);
        LSB_flag   = 1'b1;
        LSB_op     = op;
        LSB_PC     = pc;
        LSB_LS_len = len;
        LSB_data   = data;
    endtask

    // Ticks until a done pulse is seen; idx = tick index (0 = first tick), -1 if budget expires.
    task automatic wait_done(input int budget, output int idx, output logic was_lsb);
        idx     = -1;
        was_lsb = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (IF_done || LSB_done) begin
                idx     = k;
                was_lsb = LSB_done;
                break;
            end
        end
    endtask

    int          idx, nd, lsb_cnt;
    logic        was_lsb, seen;
    logic [5:0]  order;
    logic [31:0] wd;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h00;
        ram[10'h204] <= 8'h34; ram[10'h205] <= 8'h12; ram[10'h206] <= 8'hEE;
        ram[10'h200] <= 8'h77; ram[10'h201] <= 8'h66; ram[10'h202] <= 8'h55; ram[10'h203] <= 8'h44;

        rst = 1'b1; rdy = 1'b1; roll = 1'b0; io_buffer_full = 1'b0;
        IF_flag = 1'b0; IF_PC = '0;
        LSB_flag = 1'b0; LSB_op = 1'b0; LSB_PC = '0; LSB_LS_len = 3'd1; LSB_data = '0;
        tick(); tick();
        check_eq("rst mem_a", mem_a, 0);
        check_eq("rst mem_dout", mem_dout, 0);
        check_eq("rst mem_wr", mem_wr, 0);
        check_eq("rst IF_done", IF_done, 0);
        check_eq("rst IF_inst", IF_inst, 0);
        check_eq("rst LSB_done", LSB_done, 0);
        check_eq("rst LSB_val", LSB_val, 0);
        rst = 1'b0;
        tick();

        // T1: 4-byte fetch
        IF_flag = 1'b1; IF_PC = 32'h100;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) check_eq($sformatf("T1 addr%0d", k), mem_a, 32'h100 + k);
            check_eq($sformatf("T1 done%0d", k), IF_done, (k == 5));
        end
        check_eq("T1 inst", IF_inst, 32'h0000_0513);
        IF_flag = 1'b0;
        tick();
        check_eq("T1 pulse", IF_done, 0);

        // T2: 2-byte load
        lsb_req(1'b0, 32'h204, 3'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("T2 wr%0d", k), mem_wr, 0);
            check_eq($sformatf("T2 done%0d", k), LSB_done, (k == 3));
        end
        check_eq("T2 val", LSB_val, 32'h0000_1234);
        LSB_flag = 1'b0;
        tick();

        // T3: 4-byte store
        wd = 32'hAABB_CCDD;
        lsb_req(1'b1, 32'h300, 3'd4, wd);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                check_eq($sformatf("T3 wr%0d", k), mem_wr, 1);
                check_eq($sformatf("T3 addr%0d", k), mem_a, 32'h300 + k);
                check_eq($sformatf("T3 byte%0d", k), mem_dout, wd[8*k +: 8]);
            end
            check_eq($sformatf("T3 done%0d", k), LSB_done, (k == 4));
        end
        check_eq("T3 wr end", mem_wr, 0);
        check_eq("T3 ram", {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}, 32'hAABB_CCDD);
        LSB_flag = 1'b0;
        tick();

        // rdy low freezes a fetch for 3 cycles
        IF_flag = 1'b1; IF_PC = 32'h100;
        tick();
        rdy = 1'b0;
        tick(); tick(); tick();
        check_eq("rdy hold addr", mem_a, 32'h100);
        check_eq("rdy hold done", IF_done, 0);
        rdy = 1'b1;
        wait_done(20, idx, was_lsb);
        check_eq("rdy lat", idx, 4);
        check_eq("rdy inst", IF_inst, 32'h0000_0513);
        IF_flag = 1'b0;
        tick();

        // Illegal length 3 behaves as a 4-byte load
        lsb_req(1'b0, 32'h100, 3'd3, 32'h0);
        wait_done(20, idx, was_lsb);
        check_eq("len3 lat", idx, 5);
        check_eq("len3 val", LSB_val, 32'h0000_0513);
        LSB_flag = 1'b0;
        tick();

        // Set last_grant = IF, then T4: simultaneous requests
        IF_flag = 1'b1; IF_PC = 32'h100;
        wait_done(20, idx, was_lsb);
        IF_flag = 1'b0;
        tick();
        IF_flag = 1'b1; IF_PC = 32'h100;
        lsb_req(1'b0, 32'h204, 3'd1, 32'h0);
        order = '0; nd = 0; lsb_cnt = 0;
        for (int k = 0; k < 40 && nd < 3; k++) begin
            tick();
            if (LSB_done) begin
                order = {order[3:0], 2'b01};
                nd++;
                lsb_cnt++;
                if (lsb_cnt == 2) LSB_flag = 1'b0;
            end
            if (IF_done) begin
                order = {order[3:0], 2'b10};
                nd++;
                IF_flag = 1'b0;
            end
        end
        check_eq("T4 order", order, 6'b01_10_01);
        check_eq("T4 inst", IF_inst, 32'h0000_0513);
        check_eq("T4 val", LSB_val, 32'h0000_0034);
        IF_flag = 1'b0; LSB_flag = 1'b0;
        tick();

        // T5a: roll at edge 2 of a fetch
        IF_flag = 1'b1; IF_PC = 32'h100;
        tick(); tick();
        roll = 1'b1; IF_flag = 1'b0;
        tick();
        roll = 1'b0;
        check_eq("T5a addr", mem_a, 32'h101);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (IF_done || LSB_done) seen = 1'b1;
        end
        check_eq("T5a no done", seen, 0);

        // T5b: roll from edge 2 onward during a 4-byte store
        lsb_req(1'b1, 32'h310, 3'd4, 32'h1122_3344);
        idx = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 1) roll = 1'b1;
            if (LSB_done) begin
                idx = k;
                break;
            end
        end
        check_eq("T5b lat", idx, 4);
        check_eq("T5b ram", {ram[10'h313], ram[10'h312], ram[10'h311], ram[10'h310]}, 32'h1122_3344);
        roll = 1'b0; LSB_flag = 1'b0;
        tick();

        // T6: byte store to the IO region while the UART buffer is full
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 32'h3_0000, 3'd1, 32'h41);
`ifdef MEM_ARB_IO_STALL_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("T6 stall%0d", k), mem_wr, 0);
        end
        io_buffer_full = 1'b0;
        tick();
        check_eq("T6 wr", mem_wr, 1);
        check_eq("T6 byte", mem_dout, 8'h41);
        wait_done(10, idx, was_lsb);
        check_eq("T6 lat", idx, 0);
`else
        tick();
        check_eq("T6 wr", mem_wr, 1);
        wait_done(10, idx, was_lsb);
        check_eq("T6 lat", idx, 0);
`endif
        check_eq("T6 lsb", was_lsb, 1);
        check_eq("T6 ram", ram[10'h000], 8'h41);
        io_buffer_full = 1'b0; LSB_flag = 1'b0;
        tick();

        // Reset in the middle of a fetch
        IF_flag = 1'b1; IF_PC = 32'h200;
        tick(); tick();
        rst = 1'b1; IF_flag = 1'b0;
        tick();
        check_eq("mid rst addr", mem_a, 0);
        check_eq("mid rst inst", IF_inst, 0);
        check_eq("mid rst val", LSB_val, 0);
        check_eq("mid rst done", IF_done, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (IF_done || LSB_done) seen = 1'b1;
        end
        check_eq("mid rst no done", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
